// File: rtl/mem_bus_pkg.sv
// Shared encodings and the request payload carried from the masters to the memory bus.
// The request struct is sized by BUS_AW/BUS_DW; the arbiter's AW/DW must match these.
package mem_bus_pkg;

    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam int unsigned BUS_AW = 32;
    localparam int unsigned BUS_DW = 32;

    typedef struct packed {
        logic              id;
        logic              wr;
        logic [1:0]        size;
        logic [BUS_AW-1:0] addr;
        logic [3:0]        wstrb;
        logic [BUS_DW-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/req_slot.sv
// One-entry registered request stage: loads a request when told to and holds it stable
// until the bus takes it. A load in the same cycle as a fire keeps the slot full.
module req_slot
    import mem_bus_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     load_i,
    input  logic     ready_i,
    input  mem_req_t req_i,
    output logic     full_o,
    output mem_req_t req_o
);

    typedef enum logic [0:0] {SlotEmpty, SlotFull} slot_state_e;

    slot_state_e state_q, state_d;
    mem_req_t    req_q, req_d;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        unique case (state_q)
            SlotEmpty: begin
                if (load_i) begin
                    state_d = SlotFull;
                    req_d   = req_i;
                end
            end
            SlotFull: begin
                if (load_i) begin
                    req_d = req_i;
                end else if (ready_i) begin
                    state_d = SlotEmpty;
                end
            end
            default: state_d = SlotEmpty;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SlotEmpty;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    assign full_o = (state_q == SlotFull);
    assign req_o  = req_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Merges the inst (read-only) and data SRAM-like ports onto one split-transaction bus,
// tagging requests by port ID and routing responses back as one-cycle data_ok pulses.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned MAX_OUT = 2,
    parameter int unsigned AW      = BUS_AW,
    parameter int unsigned DW      = BUS_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inst_req,
    input  logic [AW-1:0] inst_addr,
    output logic          inst_addr_ok,
    output logic          inst_data_ok,
    output logic [DW-1:0] inst_rdata,
    input  logic          data_req,
    input  logic          data_wr,
    input  logic [1:0]    data_size,
    input  logic [AW-1:0] data_addr,
    input  logic [3:0]    data_wstrb,
    input  logic [DW-1:0] data_wdata,
    output logic          data_addr_ok,
    output logic          data_data_ok,
    output logic [DW-1:0] data_rdata,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic          mem_req_id,
    output logic          mem_req_wr,
    output logic [1:0]    mem_req_size,
    output logic [AW-1:0] mem_req_addr,
    output logic [3:0]    mem_req_wstrb,
    output logic [DW-1:0] mem_req_wdata,
    input  logic          mem_resp_valid,
    output logic          mem_resp_ready,
    input  logic          mem_resp_id,
    input  logic [DW-1:0] mem_resp_rdata
);

    localparam int unsigned   CW     = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] CntMax = CW'(MAX_OUT);

    logic          resp_ready_q;
    logic [CW-1:0] inst_cnt_q, inst_cnt_d, data_cnt_q, data_cnt_d;
    logic          inst_data_ok_q, inst_data_ok_d, data_data_ok_q, data_data_ok_d;
    logic [DW-1:0] inst_rdata_q, inst_rdata_d, data_rdata_q, data_rdata_d;

    logic     resp_fire, inst_resp, data_resp;
    logic     slot_full, slot_free, inst_accept, data_accept;
    mem_req_t slot_req_in, slot_req_out;

    always_comb begin
        resp_fire = mem_resp_valid & resp_ready_q;
        // Responses for a port with nothing outstanding are dropped.
        inst_resp = resp_fire & (mem_resp_id == ID_INST) & (inst_cnt_q != '0);
        data_resp = resp_fire & (mem_resp_id == ID_DATA) & (data_cnt_q != '0);

        slot_free   = ~slot_full | mem_req_ready;
        data_accept = ~rst & data_req & slot_free & ((data_cnt_q < CntMax) | data_resp);
        inst_accept = ~rst & inst_req & slot_free & ((inst_cnt_q < CntMax) | inst_resp)
                      & ~data_accept;

        slot_req_in = '0;
        if (data_accept) begin
            slot_req_in.id    = ID_DATA;
            slot_req_in.wr    = data_wr;
            slot_req_in.size  = data_size;
            slot_req_in.addr  = data_addr;
            slot_req_in.wstrb = data_wr ? data_wstrb : 4'h0;
            slot_req_in.wdata = data_wdata;
        end else begin
            slot_req_in.id    = ID_INST;
            slot_req_in.size  = SIZE_W;
            slot_req_in.addr  = inst_addr;
        end

        inst_cnt_d = inst_cnt_q + CW'(inst_accept) - CW'(inst_resp);
        data_cnt_d = data_cnt_q + CW'(data_accept) - CW'(data_resp);

        inst_data_ok_d = inst_resp;
        data_data_ok_d = data_resp;
        inst_rdata_d   = inst_resp ? mem_resp_rdata : inst_rdata_q;
        data_rdata_d   = data_resp ? mem_resp_rdata : data_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_ready_q   <= 1'b0;
            inst_cnt_q     <= '0;
            data_cnt_q     <= '0;
            inst_data_ok_q <= 1'b0;
            data_data_ok_q <= 1'b0;
            inst_rdata_q   <= '0;
            data_rdata_q   <= '0;
        end else begin
            resp_ready_q   <= 1'b1;
            inst_cnt_q     <= inst_cnt_d;
            data_cnt_q     <= data_cnt_d;
            inst_data_ok_q <= inst_data_ok_d;
            data_data_ok_q <= data_data_ok_d;
            inst_rdata_q   <= inst_rdata_d;
            data_rdata_q   <= data_rdata_d;
        end
    end

    req_slot u_req_slot (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (inst_accept | data_accept),
        .ready_i (mem_req_ready),
        .req_i   (slot_req_in),
        .full_o  (slot_full),
        .req_o   (slot_req_out)
    );

    assign inst_addr_ok   = inst_accept;
    assign data_addr_ok   = data_accept;
    assign inst_data_ok   = inst_data_ok_q;
    assign data_data_ok   = data_data_ok_q;
    assign inst_rdata     = inst_rdata_q;
    assign data_rdata     = data_rdata_q;
    assign mem_resp_ready = resp_ready_q;

    assign mem_req_valid = slot_full;
    assign mem_req_id    = slot_req_out.id;
    assign mem_req_wr    = slot_req_out.wr;
    assign mem_req_size  = slot_req_out.size;
    assign mem_req_addr  = slot_req_out.addr;
    assign mem_req_wstrb = slot_req_out.wstrb;
    assign mem_req_wdata = slot_req_out.wdata;

endmodule
